pipeline_control: RTL and testbench
===================================

# pipeline_control

Central sequencer for the five-stage pipeline. It drives the `en` and `flush` inputs of the fetch, decode, execute and memory latches and the PC enable. It resolves data-cache stalls, load-use hazards, taken branches and jumps, instruction-cache misses and halt draining. It sits beside the datapath and reads its inputs from the latch outputs and the cache hit lines.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  synchronous reset, active-high; one clock, reset is synchronous and active-high
- ihit  in  1  instruction cache hit for the current fetch
- dhit  in  1  data cache hit for the memory-stage request
- mem_dREN, mem_dWEN  in  1 each  memory-stage read/write request (execute latch out_dREN/out_dWEN)
- mem_halt  in  1  halt instruction in memory stage (execute latch out_halt)
- mem_pcsrc  in  1  taken branch or jump resolved in memory stage
- ex_dREN  in  1  load in execute stage (decode latch out_dREN)
- ex_wsel  in  5  destination register of the execute-stage instruction
- dec_rs, dec_rt  in  5 each  source registers of the decode-stage instruction
- pc_en  out  1  PC update enable
- if_en, id_en, ex_en, mem_en  out  1 each  latch enables: fetch, decode, execute, memory
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  latch synchronous clears
- halted  out  1  registered; pipeline drained after halt

## Operation
- States:
  - RUN: normal operation.
  - DSTALL: waiting on the data cache.
  - HALT: terminal state.
- Definitions:
  - mem_req = mem_dREN | mem_dWEN
  - dstall = mem_req & !dhit
  - lu_hazard = ex_dREN & (ex_wsel != 0) & ((ex_wsel == dec_rs) | (ex_wsel == dec_rt))
- Outputs in RUN/DSTALL are combinational. The first matching rule applies (strict priority):
  1. dstall: pc_en = 0, all en = 0, all flush = 0. Every stage freezes.
  2. mem_pcsrc: pc_en = 1, if_flush = id_flush = ex_flush = 1, mem_en = 1. Squashes three younger instructions.
  3. lu_hazard: pc_en = 0, if_en = 0, id_flush = 1 (bubble into execute), ex_en = mem_en = 1.
  4. !ihit: pc_en = 0, if_flush = 1 (bubble into decode), id_en = ex_en = mem_en = 1.
  5. Otherwise: pc_en = 1, all en = 1, all flush = 0.
- Any flush not set by the winning rule is 0. Any en not named by the winning rule is 0. When a latch's flush and en are both 1, flush wins in the latch.
- Transitions:
  - RUN→DSTALL on dstall.
  - DSTALL→RUN on dhit, or when mem_req drops.
  - RUN or DSTALL→HALT when mem_halt & !dstall.
  - HALT persists until RST.
- HALT: pc_en = 0, all en = 0, all flush = 0, halted = 1.
- Data hazards other than load-use are handled by the forwarding unit, not here.

## Timing
- Reset values (RST high at a rising edge, and combinationally while RST = 1): state = RUN, halted = 0, pc_en = 0, all en = 0, all flush = 1, counters = 0.
- Combinational path from inputs to en/flush/pc_en. No added latency.
- halted rises one cycle after the edge where mem_halt & !dstall is sampled.
- dhit and mem_pcsrc in the same cycle with a request pending: dstall = 0, so rule 2 applies in that cycle.
- mem_halt with dstall: the halt is deferred until the access completes.
- mem_halt with mem_pcsrc: the branch flush is applied this cycle and HALT is entered next.
- lu_hazard holds for exactly one cycle per load: after the bubble, ex_dREN = 0.
- RST asserted mid-DSTALL or in HALT: the next edge returns to RUN and halted = 0.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds two 32-bit outputs, saturating at 0xFFFFFFFF and cleared by RST.
  - dstall_cnt: increments every cycle rule 1 is active.
  - hazard_cnt: increments every cycle rule 2 or rule 3 is active.
  - Neither counter increments in HALT.
- PIPE_CTRL_PERF_EN undefined: these ports and registers are absent. Behaviour is otherwise identical.

## Test plan
- Reset: RST = 1 for 2 cycles with random inputs -> all flush = 1, all en = 0, pc_en = 0, halted = 0; after release with ihit = 1 and others 0 -> all en = 1, pc_en = 1.
- Data stall: mem_dREN = 1, dhit = 0 for 3 cycles, then dhit = 1 -> 3 cycles of all en = 0 and pc_en = 0, then all en = 1; dstall_cnt = 3 with the macro.
- Load-use: ex_dREN = 1, ex_wsel = 8, dec_rt = 8 -> pc_en = 0, if_en = 0, id_flush = 1, ex_en = 1. Same inputs with ex_wsel = 0 -> all en = 1.
- Branch priority: mem_pcsrc = 1, lu_hazard = 1, ihit = 0 -> pc_en = 1, if/id/ex_flush = 1, mem_en = 1.
- Halt under stall: mem_halt = 1, mem_dWEN = 1, dhit = 0 for 2 cycles, then dhit = 1 -> halted = 1 one cycle after the dhit edge and stays 1; all en = 0 thereafter until RST.
- Miss bubble: ihit = 0, no other events -> if_flush = 1, pc_en = 0, id/ex/mem_en = 1.

Source files
------------

// File: rtl/pipeline_control.sv
// Five-stage pipeline sequencer: stalls, load-use bubbles, branch squash, halt drain.
// Optional perf counters (dstall_cnt, hazard_cnt) enabled by PIPE_CTRL_PERF_EN.
module pipeline_control (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       mem_dREN,
    input  logic       mem_dWEN,
    input  logic       mem_halt,
    input  logic       mem_pcsrc,
    input  logic       ex_dREN,
    input  logic [4:0] ex_wsel,
    input  logic [4:0] dec_rs,
    input  logic [4:0] dec_rt,
    output logic       pc_en,
    output logic       if_en,
    output logic       id_en,
    output logic       ex_en,
    output logic       mem_en,
    output logic       if_flush,
    output logic       id_flush,
    output logic       ex_flush,
    output logic       mem_flush,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] dstall_cnt,
    output logic [31:0] hazard_cnt,
`endif
    output logic       halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        HALT   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   halted_q, halted_d;

    logic mem_req, dstall, lu_hazard;
    logic rule_dstall, rule_hazard;

    assign mem_req   = mem_dREN | mem_dWEN;
    assign dstall    = mem_req & ~dhit;
    assign lu_hazard = ex_dREN & (ex_wsel != 5'd0) &
                       ((ex_wsel == dec_rs) | (ex_wsel == dec_rt));

    always_comb begin
        pc_en       = 1'b0;
        if_en       = 1'b0;
        id_en       = 1'b0;
        ex_en       = 1'b0;
        mem_en      = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        mem_flush   = 1'b0;
        rule_dstall = 1'b0;
        rule_hazard = 1'b0;
        if (RST) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
        end else if (state_q != HALT) begin
            if (dstall) begin
                rule_dstall = 1'b1;
            end else if (mem_pcsrc) begin
                rule_hazard = 1'b1;
                pc_en       = 1'b1;
                if_flush    = 1'b1;
                id_flush    = 1'b1;
                ex_flush    = 1'b1;
                mem_en      = 1'b1;
            end else if (lu_hazard) begin
                // Hold fetch/decode, inject a bubble into execute.
                rule_hazard = 1'b1;
                id_flush    = 1'b1;
                ex_en       = 1'b1;
                mem_en      = 1'b1;
            end else if (!ihit) begin
                if_flush = 1'b1;
                id_en    = 1'b1;
                ex_en    = 1'b1;
                mem_en   = 1'b1;
            end else begin
                pc_en  = 1'b1;
                if_en  = 1'b1;
                id_en  = 1'b1;
                ex_en  = 1'b1;
                mem_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_halt && !dstall) state_d = HALT;
                else if (dstall)         state_d = DSTALL;
            end
            DSTALL: begin
                if (mem_halt && !dstall) state_d = HALT;
                else if (!dstall)        state_d = RUN;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q & ~RST;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] dstall_cnt_q, dstall_cnt_d;
    logic [31:0] hazard_cnt_q, hazard_cnt_d;

    always_comb begin
        dstall_cnt_d = dstall_cnt_q;
        hazard_cnt_d = hazard_cnt_q;
        if (rule_dstall && dstall_cnt_q != 32'hFFFF_FFFF)
            dstall_cnt_d = dstall_cnt_q + 32'd1;
        if (rule_hazard && hazard_cnt_q != 32'hFFFF_FFFF)
            hazard_cnt_d = hazard_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dstall_cnt_q <= 32'd0;
            hazard_cnt_q <= 32'd0;
        end else begin
            dstall_cnt_q <= dstall_cnt_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign dstall_cnt = RST ? 32'd0 : dstall_cnt_q;
    assign hazard_cnt = RST ? 32'd0 : hazard_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = rule_dstall ^ rule_hazard;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized and directed checks of pipeline_control against a rule-table model.
module tb_pipeline_control;

    logic       CLK = 1'b0;
    logic       RST, ihit, dhit, mem_dREN, mem_dWEN, mem_halt, mem_pcsrc, ex_dREN;
    logic [4:0] ex_wsel, dec_rs, dec_rt;
    logic       pc_en, if_en, id_en, ex_en, mem_en;
    logic       if_flush, id_flush, ex_flush, mem_flush, halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] dstall_cnt, hazard_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    pipeline_control dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
        .mem_pcsrc(mem_pcsrc), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
        .dec_rs(dec_rs), .dec_rt(dec_rt),
        .pc_en(pc_en), .if_en(if_en), .id_en(id_en), .ex_en(ex_en),
        .mem_en(mem_en), .if_flush(if_flush), .id_flush(id_flush),
        .ex_flush(ex_flush), .mem_flush(mem_flush),
`ifdef PIPE_CTRL_PERF_EN
        .dstall_cnt(dstall_cnt), .hazard_cnt(hazard_cnt),
`endif
        .halted(halted)
    );

    // {pc_en, if/id/ex/mem_en, if/id/ex/mem_flush}
    logic [8:0] ctrl;
    assign ctrl = {pc_en, if_en, id_en, ex_en, mem_en,
                   if_flush, id_flush, ex_flush, mem_flush};

    localparam logic [8:0] C_RESET  = 9'b0_0000_1111;
    localparam logic [8:0] C_FREEZE = 9'b0_0000_0000;
    localparam logic [8:0] C_RUN    = 9'b1_1111_0000;
    localparam logic [8:0] C_BRANCH = 9'b1_0001_1110;
    localparam logic [8:0] C_LOAD   = 9'b0_0011_0100;
    localparam logic [8:0] C_MISS   = 9'b0_0111_1000;

    // Reference model: a halted flag and two event counters.
    logic        m_halted = 1'b0;
    logic [31:0] m_dc = 0, m_hc = 0;

    function automatic logic f_dstall();
        return (mem_dREN | mem_dWEN) & ~dhit;
    endfunction

    function automatic logic f_lu();
        return ex_dREN && ex_wsel != 0 && (ex_wsel == dec_rs || ex_wsel == dec_rt);
    endfunction

    function automatic logic [8:0] f_ctrl();
        if (RST)       return C_RESET;
        if (m_halted)  return C_FREEZE;
        if (f_dstall()) return C_FREEZE;
        if (mem_pcsrc) return C_BRANCH;
        if (f_lu())    return C_LOAD;
        if (!ihit)     return C_MISS;
        return C_RUN;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_halted <= 1'b0;
            m_dc     <= 0;
            m_hc     <= 0;
        end else if (!m_halted) begin
            if (f_dstall()) begin
                if (m_dc != 32'hFFFF_FFFF) m_dc <= m_dc + 1;
            end else begin
                if ((mem_pcsrc || f_lu()) && m_hc != 32'hFFFF_FFFF) m_hc <= m_hc + 1;
                if (mem_halt) m_halted <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_halt = 1'b0; mem_pcsrc = 1'b0; ex_dREN = 1'b0;
        ex_wsel = 5'd0; dec_rs = 5'd0; dec_rt = 5'd0;
    endtask

    task automatic rand_inputs();
        ihit      = ($urandom_range(0, 3) != 0);
        dhit      = $urandom_range(0, 1) == 1;
        mem_dREN  = ($urandom_range(0, 2) == 0);
        mem_dWEN  = ($urandom_range(0, 4) == 0);
        mem_halt  = ($urandom_range(0, 29) == 0);
        mem_pcsrc = ($urandom_range(0, 4) == 0);
        ex_dREN   = ($urandom_range(0, 1) == 1);
        ex_wsel   = 5'($urandom_range(0, 3));
        dec_rs    = 5'($urandom_range(0, 3));
        dec_rt    = 5'($urandom_range(0, 3));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        quiet();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            @(negedge CLK);
            vectors++;
            if ({ctrl, halted} !== {C_RESET, 1'b0}) begin
                miscompares++;
                $display("FAIL reset[%0d] ctrl/halted got %b want %b", i, {ctrl, halted}, {C_RESET, 1'b0});
            end
            tick();
        end
        RST = 1'b0;
        quiet();
        @(negedge CLK);
        vectors++;
        if ({ctrl, halted} !== {C_RUN, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release got %b want %b", {ctrl, halted}, {C_RUN, 1'b0});
        end
`ifdef PIPE_CTRL_PERF_EN
        vectors++;
        if ({dstall_cnt, hazard_cnt} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", dstall_cnt, hazard_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_dstall();
        do_reset();
        mem_dREN = 1'b1;
        dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            vectors++;
            if (ctrl !== C_FREEZE) begin
                miscompares++;
                $display("FAIL dstall[%0d] got %b want %b", i, ctrl, C_FREEZE);
            end
            tick();
        end
        dhit = 1'b1;
        @(negedge CLK);
        vectors++;
        if (ctrl !== C_RUN) begin
            miscompares++;
            $display("FAIL dstall_done got %b want %b", ctrl, C_RUN);
        end
        tick();
        quiet();
`ifdef PIPE_CTRL_PERF_EN
        @(negedge CLK);
        vectors++;
        if (dstall_cnt !== 32'd3) begin
            miscompares++;
            $display("FAIL dstall_cnt got %0d want 3", dstall_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_dREN = 1'b1; ex_wsel = 5'd8; dec_rt = 5'd8; dec_rs = 5'd3;
        @(negedge CLK);
        vectors++;
        if (ctrl !== C_LOAD) begin
            miscompares++;
            $display("FAIL load_use got %b want %b", ctrl, C_LOAD);
        end
        tick();
        ex_wsel = 5'd0; dec_rt = 5'd0;
        @(negedge CLK);
        vectors++;
        if (ctrl !== C_RUN) begin
            miscompares++;
            $display("FAIL load_use_r0 got %b want %b", ctrl, C_RUN);
        end
        tick();
        quiet();
    endtask

    task automatic test_branch_priority();
        do_reset();
        mem_pcsrc = 1'b1; ihit = 1'b0;
        ex_dREN = 1'b1; ex_wsel = 5'd5; dec_rs = 5'd5;
        @(negedge CLK);
        vectors++;
        if (ctrl !== C_BRANCH) begin
            miscompares++;
            $display("FAIL branch_prio got %b want %b", ctrl, C_BRANCH);
        end
        tick();
        // dhit arriving with the branch: request resolved, branch wins
        quiet();
        mem_dREN = 1'b1; dhit = 1'b1; mem_pcsrc = 1'b1;
        @(negedge CLK);
        vectors++;
        if (ctrl !== C_BRANCH) begin
            miscompares++;
            $display("FAIL branch_dhit got %b want %b", ctrl, C_BRANCH);
        end
        tick();
        quiet();
`ifdef PIPE_CTRL_PERF_EN
        @(negedge CLK);
        vectors++;
        if (hazard_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL hazard_cnt got %0d want 2", hazard_cnt);
        end
`endif
    endtask

    task automatic test_miss();
        do_reset();
        ihit = 1'b0;
        @(negedge CLK);
        vectors++;
        if (ctrl !== C_MISS) begin
            miscompares++;
            $display("FAIL miss got %b want %b", ctrl, C_MISS);
        end
        tick();
        quiet();
    endtask

    task automatic test_halt_stall();
        do_reset();
        mem_halt = 1'b1; mem_dWEN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            vectors++;
            if ({ctrl, halted} !== {C_FREEZE, 1'b0}) begin
                miscompares++;
                $display("FAIL halt_wait[%0d] got %b want %b", i, {ctrl, halted}, {C_FREEZE, 1'b0});
            end
            tick();
        end
        dhit = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({ctrl, halted} !== {C_RUN, 1'b0}) begin
            miscompares++;
            $display("FAIL halt_dhit got %b want %b", {ctrl, halted}, {C_RUN, 1'b0});
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            @(negedge CLK);
            vectors++;
            if ({ctrl, halted} !== {C_FREEZE, 1'b1}) begin
                miscompares++;
                $display("FAIL halted[%0d] got %b want %b", i, {ctrl, halted}, {C_FREEZE, 1'b1});
            end
            tick();
        end
        RST = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({ctrl, halted} !== {C_RESET, 1'b0}) begin
            miscompares++;
            $display("FAIL halt_rst got %b want %b", {ctrl, halted}, {C_RESET, 1'b0});
        end
        tick();
        RST = 1'b0;
        quiet();
        @(negedge CLK);
        vectors++;
        if ({ctrl, halted} !== {C_RUN, 1'b0}) begin
            miscompares++;
            $display("FAIL halt_exit got %b want %b", {ctrl, halted}, {C_RUN, 1'b0});
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            RST = ($urandom_range(0, 39) == 0);
            @(negedge CLK);
            vectors++;
            if ({ctrl, halted} !== {f_ctrl(), m_halted & ~RST}) begin
                miscompares++;
                $display("FAIL random[%0d] got %b want %b", i, {ctrl, halted}, {f_ctrl(), m_halted & ~RST});
            end
`ifdef PIPE_CTRL_PERF_EN
            vectors++;
            if (!RST && {dstall_cnt, hazard_cnt} !== {m_dc, m_hc}) begin
                miscompares++;
                $display("FAIL random_cnt[%0d] got %0d/%0d want %0d/%0d", i, dstall_cnt, hazard_cnt, m_dc, m_hc);
            end
`endif
            tick();
        end
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        quiet();
        tick();
        test_reset();
        test_dstall();
        test_load_use();
        test_branch_priority();
        test_miss();
        test_halt_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
